// File: rtl/uart_pkg.sv
// Shared types and constants for the UART program loader.
// Optional build macro UART_PARITY_EN selects 8E1 framing (RX_PARITY state used).
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Marker word the CPU top watches for to leave load mode.
  localparam logic [15:0] RUN_MARKER = 16'h1111;

endpackage

// File: rtl/uart_program_loader_if.sv
// Word-output bus of the UART program loader (loader = master, consumer = slave).
// Build macro UART_PARITY_EN adds the parity_error pulse.
interface uart_program_loader_if;
  logic        data_valid;
  logic [31:0] data_out;
  logic [31:0] byte_address;
  logic        frame_error;
  logic        load_active;
`ifdef UART_PARITY_EN
  logic        parity_error;
`endif

  modport master (
    output data_valid, data_out, byte_address, frame_error, load_active
`ifdef UART_PARITY_EN
    , parity_error
`endif
  );

  modport slave (
    input data_valid, data_out, byte_address, frame_error, load_active
`ifdef UART_PARITY_EN
    , parity_error
`endif
  );
endinterface

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, bit-timing counter and receive FSM.
// Build macro UART_PARITY_EN: 8E1 framing with parity_error output; otherwise 8N1.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
`ifdef UART_PARITY_EN
  , output logic     parity_error
`endif
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q, rx_sync_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_error_q, frame_error_d;
`ifdef UART_PARITY_EN
  logic            parity_bit_q, parity_bit_d;
  logic            parity_error_q, parity_error_d;
`endif

  // Synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= io_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RX_IDLE;
      clk_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      byte_valid_q   <= 1'b0;
      frame_error_q  <= 1'b0;
`ifdef UART_PARITY_EN
      parity_bit_q   <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      clk_cnt_q      <= clk_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      byte_valid_q   <= byte_valid_d;
      frame_error_q  <= frame_error_d;
`ifdef UART_PARITY_EN
      parity_bit_q   <= parity_bit_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  // Next-state logic: sample at the start-bit midpoint, then once per bit period.
  always_comb begin
    state_d        = state_q;
    clk_cnt_d      = clk_cnt_q + 1'b1;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    byte_valid_d   = 1'b0;
    frame_error_d  = 1'b0;
`ifdef UART_PARITY_EN
    parity_bit_d   = parity_bit_q;
    parity_error_d = 1'b0;
`endif
    case (state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync_q) begin
          state_d   = RX_START;
          bit_cnt_d = '0;
        end
      end
      RX_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d    = '0;
          parity_bit_d = rx_sync_q;
          state_d      = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          state_d   = RX_IDLE;
          if (!rx_sync_q) begin
            frame_error_d = 1'b1;
`ifdef UART_PARITY_EN
          end else if (parity_bit_q != (^shift_q)) begin
            parity_error_d = 1'b1;
`endif
          end else begin
            byte_valid_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = shift_q;
  assign frame_error  = frame_error_q;
`ifdef UART_PARITY_EN
  assign parity_error = parity_error_q;
`endif

endmodule

// File: rtl/uart_program_loader.sv
// UART program loader: packs received bytes into little-endian 32-bit words
// with a word-aligned byte address. Build macro UART_PARITY_EN selects 8E1.
module uart_program_loader
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_rx,
  uart_program_loader_if.master  bus
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_frame_error;
`ifdef UART_PARITY_EN
  logic       rx_parity_error;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .io_rx        (io_rx),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .frame_error  (rx_frame_error)
`ifdef UART_PARITY_EN
    , .parity_error (rx_parity_error)
`endif
  );

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic        data_valid_q, data_valid_d;
  logic [31:0] data_out_q, data_out_d;
  logic [31:0] byte_address_q, byte_address_d;

  // Word assembler and address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q     <= '0;
      word_q         <= '0;
      addr_q         <= BASE_ADDR;
      data_valid_q   <= 1'b0;
      data_out_q     <= '0;
      byte_address_q <= BASE_ADDR;
    end else begin
      byte_cnt_q     <= byte_cnt_d;
      word_q         <= word_d;
      addr_q         <= addr_d;
      data_valid_q   <= data_valid_d;
      data_out_q     <= data_out_d;
      byte_address_q <= byte_address_d;
    end
  end

  // Lanes 0..2 are buffered; lane 3 goes straight into the output word.
  always_comb begin
    byte_cnt_d     = byte_cnt_q;
    word_d         = word_q;
    addr_d         = addr_q;
    data_valid_d   = 1'b0;
    data_out_d     = data_out_q;
    byte_address_d = byte_address_q;
    if (data_valid_q) begin
      addr_d = addr_q + 32'd4;
    end
    if (byte_valid) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
        data_valid_d   = 1'b1;
        data_out_d     = {byte_data, word_q};
        byte_address_d = addr_q;
      end else begin
        case (byte_cnt_q)
          2'd0:    word_d[7:0]   = byte_data;
          2'd1:    word_d[15:8]  = byte_data;
          default: word_d[23:16] = byte_data;
        endcase
      end
    end
  end

  assign bus.data_valid   = data_valid_q;
  assign bus.data_out     = data_out_q;
  assign bus.byte_address = byte_address_q;
  assign bus.frame_error  = rx_frame_error;
  assign bus.load_active  = (byte_cnt_q != 2'd0);
`ifdef UART_PARITY_EN
  assign bus.parity_error = rx_parity_error;
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
// Testbench for uart_program_loader (CLKS_PER_BIT=16). Build macro
// UART_PARITY_EN enables 8E1 framing and the parity scenario.
module tb_uart_program_loader;
  import uart_pkg::*;

  localparam int unsigned CPB  = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  logic io_rx;

  uart_program_loader_if bus ();

  uart_program_loader #(
    .CLKS_PER_BIT (CPB),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_rx (io_rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: accepted bytes of the current word and next word address.
  logic [7:0]  m_bytes[$];
  logic [31:0] m_addr;
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] obs_addr[$];
  int unsigned fe_cnt  = 0;
  int unsigned pe_cnt  = 0;
  int unsigned dv_long = 0;
  logic        dv_prev = 1'b0;
  int          errors  = 0;
  int          checks  = 0;
`ifdef UART_PARITY_EN
  logic        par_flip = 1'b0;
`endif

  // Observe outputs on the falling edge.
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      obs_data.push_back(bus.data_out);
      obs_addr.push_back(bus.byte_address);
      if (dv_prev) dv_long++;
    end
    dv_prev = (bus.data_valid === 1'b1);
    if (bus.frame_error === 1'b1) fe_cnt++;
`ifdef UART_PARITY_EN
    if (bus.parity_error === 1'b1) pe_cnt++;
`endif
  end

  task automatic model_byte(input logic [7:0] b);
    m_bytes.push_back(b);
    if (m_bytes.size() == BYTES_PER_WORD) begin
      exp_data.push_back({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
      exp_addr.push_back(m_addr);
      m_addr = m_addr + 32'd4;
      m_bytes.delete();
    end
  endtask

  task automatic send_bit(input logic v);
    io_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    send_bit(stop_v);
    io_rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b1);
    model_byte(b);
  endtask

  task automatic wait_strobes(input int n, output bit ok);
    int unsigned t = 0;
    while (obs_data.size() < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
    ok = (obs_data.size() >= n);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    io_rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rst_data_valid got=%b want=0", bus.data_valid); end
    checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL rst_data_out got=%h want=0", bus.data_out); end
    checks++; if (bus.byte_address !== BASE) begin errors++; $display("FAIL rst_byte_address got=%h want=%h", bus.byte_address, BASE); end
    checks++; if (bus.frame_error !== 1'b0) begin errors++; $display("FAIL rst_frame_error got=%b want=0", bus.frame_error); end
    checks++; if (bus.load_active !== 1'b0) begin errors++; $display("FAIL rst_load_active got=%b want=0", bus.load_active); end
    reset = 1'b0;
    m_addr = BASE;
    m_bytes.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    logic [7:0] seq[8] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h11, 8'h11, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) send_good(seq[i]);
    wait_strobes(exp_data.size(), ok);
    checks++; if (!ok || obs_data.size() != exp_data.size()) begin errors++; $display("FAIL basic_count got=%0d want=%0d", obs_data.size(), exp_data.size()); end
    if (obs_data.size() >= 2) begin
      checks++; if (obs_data[1][15:0] !== RUN_MARKER) begin errors++; $display("FAIL basic_marker got=%h want=%h", obs_data[1][15:0], RUN_MARKER); end
    end
    while (obs_data.size() > 0 && exp_data.size() > 0) begin
      checks++; if (obs_data[0] !== exp_data[0]) begin errors++; $display("FAIL basic_data got=%h want=%h", obs_data[0], exp_data[0]); end
      checks++; if (obs_addr[0] !== exp_addr[0]) begin errors++; $display("FAIL basic_addr got=%h want=%h", obs_addr[0], exp_addr[0]); end
      void'(obs_data.pop_front()); void'(obs_addr.pop_front());
      void'(exp_data.pop_front()); void'(exp_addr.pop_front());
    end
    obs_data.delete(); obs_addr.delete(); exp_data.delete(); exp_addr.delete();
  endtask

  task automatic test_glitch;
    bit ok;
    int unsigned fe0;
    send_good(8'($urandom));
    fe0 = fe_cnt;
    io_rx = 1'b0;
    repeat (5) @(negedge clk);
    io_rx = 1'b1;
    repeat (80) @(negedge clk);
    checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL glitch_frame_error got=%0d want=%0d", fe_cnt, fe0); end
    checks++; if (obs_data.size() != 0) begin errors++; $display("FAIL glitch_strobe got=%0d want=0", obs_data.size()); end
    checks++; if (bus.load_active !== (m_bytes.size() != 0)) begin errors++; $display("FAIL glitch_load_active got=%b want=%b", bus.load_active, m_bytes.size() != 0); end
    for (int i = 0; i < 3; i++) send_good(8'($urandom));
    wait_strobes(exp_data.size(), ok);
    checks++; if (!ok || obs_data.size() != exp_data.size()) begin errors++; $display("FAIL glitch_count got=%0d want=%0d", obs_data.size(), exp_data.size()); end
    while (obs_data.size() > 0 && exp_data.size() > 0) begin
      checks++; if (obs_data[0] !== exp_data[0]) begin errors++; $display("FAIL glitch_data got=%h want=%h", obs_data[0], exp_data[0]); end
      checks++; if (obs_addr[0] !== exp_addr[0]) begin errors++; $display("FAIL glitch_addr got=%h want=%h", obs_addr[0], exp_addr[0]); end
      void'(obs_data.pop_front()); void'(obs_addr.pop_front());
      void'(exp_data.pop_front()); void'(exp_addr.pop_front());
    end
    obs_data.delete(); obs_addr.delete(); exp_data.delete(); exp_addr.delete();
  endtask

  task automatic test_frame_error;
    bit ok;
    int unsigned fe0;
    send_good(8'($urandom));
    send_good(8'($urandom));
    fe0 = fe_cnt;
    send_byte(8'hAA, 1'b0);
    repeat (40) @(negedge clk);
    checks++; if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL ferr_pulses got=%0d want=%0d", fe_cnt - fe0, 1); end
    checks++; if (bus.load_active !== 1'b1) begin errors++; $display("FAIL ferr_load_active got=%b want=1", bus.load_active); end
    checks++; if (obs_data.size() != 0) begin errors++; $display("FAIL ferr_early_strobe got=%0d want=0", obs_data.size()); end
    send_good(8'($urandom));
    send_good(8'($urandom));
    wait_strobes(exp_data.size(), ok);
    checks++; if (!ok || obs_data.size() != exp_data.size()) begin errors++; $display("FAIL ferr_count got=%0d want=%0d", obs_data.size(), exp_data.size()); end
    while (obs_data.size() > 0 && exp_data.size() > 0) begin
      checks++; if (obs_data[0] !== exp_data[0]) begin errors++; $display("FAIL ferr_data got=%h want=%h", obs_data[0], exp_data[0]); end
      checks++; if (obs_addr[0] !== exp_addr[0]) begin errors++; $display("FAIL ferr_addr got=%h want=%h", obs_addr[0], exp_addr[0]); end
      void'(obs_data.pop_front()); void'(obs_addr.pop_front());
      void'(exp_data.pop_front()); void'(exp_addr.pop_front());
    end
    obs_data.delete(); obs_addr.delete(); exp_data.delete(); exp_addr.delete();
  endtask

  task automatic test_reset_mid_word;
    bit ok;
    for (int i = 0; i < 3; i++) send_good(8'($urandom));
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_bytes.delete();
    m_addr = BASE;
    checks++; if (bus.load_active !== 1'b0) begin errors++; $display("FAIL rstmid_load_active got=%b want=0", bus.load_active); end
    checks++; if (bus.byte_address !== BASE) begin errors++; $display("FAIL rstmid_byte_address got=%h want=%h", bus.byte_address, BASE); end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) send_good(8'($urandom));
    wait_strobes(exp_data.size(), ok);
    checks++; if (!ok || obs_data.size() != exp_data.size()) begin errors++; $display("FAIL rstmid_count got=%0d want=%0d", obs_data.size(), exp_data.size()); end
    while (obs_data.size() > 0 && exp_data.size() > 0) begin
      checks++; if (obs_data[0] !== exp_data[0]) begin errors++; $display("FAIL rstmid_data got=%h want=%h", obs_data[0], exp_data[0]); end
      checks++; if (obs_addr[0] !== exp_addr[0]) begin errors++; $display("FAIL rstmid_addr got=%h want=%h", obs_addr[0], exp_addr[0]); end
      void'(obs_data.pop_front()); void'(obs_addr.pop_front());
      void'(exp_data.pop_front()); void'(exp_addr.pop_front());
    end
    obs_data.delete(); obs_addr.delete(); exp_data.delete(); exp_addr.delete();
  endtask

  task automatic test_back_to_back;
    bit ok;
    for (int i = 0; i < 32; i++) send_good(8'($urandom));
    wait_strobes(exp_data.size(), ok);
    checks++; if (!ok || obs_data.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", obs_data.size()); end
    checks++; if (dv_long != 0) begin errors++; $display("FAIL b2b_strobe_width got=%0d want=0", dv_long); end
    while (obs_data.size() > 0 && exp_data.size() > 0) begin
      checks++; if (obs_data[0] !== exp_data[0]) begin errors++; $display("FAIL b2b_data got=%h want=%h", obs_data[0], exp_data[0]); end
      checks++; if (obs_addr[0] !== exp_addr[0]) begin errors++; $display("FAIL b2b_addr got=%h want=%h", obs_addr[0], exp_addr[0]); end
      void'(obs_data.pop_front()); void'(obs_addr.pop_front());
      void'(exp_data.pop_front()); void'(exp_addr.pop_front());
    end
    obs_data.delete(); obs_addr.delete(); exp_data.delete(); exp_addr.delete();
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    bit ok;
    int unsigned pe0, fe0;
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    par_flip = 1'b1;
    send_byte(8'h07, 1'b1);
    par_flip = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (pe_cnt !== pe0 + 1) begin errors++; $display("FAIL par_pulses got=%0d want=1", pe_cnt - pe0); end
    checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL par_frame_error got=%0d want=0", fe_cnt - fe0); end
    checks++; if (bus.load_active !== (m_bytes.size() != 0)) begin errors++; $display("FAIL par_discard got=%b want=%b", bus.load_active, m_bytes.size() != 0); end
    send_good(8'h07);
    repeat (20) @(negedge clk);
    checks++; if (bus.load_active !== 1'b1) begin errors++; $display("FAIL par_accept got=%b want=1", bus.load_active); end
    for (int i = 0; i < 3; i++) send_good(8'($urandom));
    wait_strobes(exp_data.size(), ok);
    checks++; if (!ok || obs_data.size() != exp_data.size()) begin errors++; $display("FAIL par_count got=%0d want=%0d", obs_data.size(), exp_data.size()); end
    while (obs_data.size() > 0 && exp_data.size() > 0) begin
      checks++; if (obs_data[0] !== exp_data[0]) begin errors++; $display("FAIL par_data got=%h want=%h", obs_data[0], exp_data[0]); end
      checks++; if (obs_addr[0] !== exp_addr[0]) begin errors++; $display("FAIL par_addr got=%h want=%h", obs_addr[0], exp_addr[0]); end
      void'(obs_data.pop_front()); void'(obs_addr.pop_front());
      void'(exp_data.pop_front()); void'(exp_addr.pop_front());
    end
    obs_data.delete(); obs_addr.delete(); exp_data.delete(); exp_addr.delete();
  endtask
`endif

  initial begin
    reset = 1'b1;
    io_rx = 1'b1;
    m_addr = BASE;
    @(negedge clk);
    test_reset;
    test_basic;
    test_glitch;
    test_frame_error;
    test_reset_mid_word;
    test_back_to_back;
`ifdef UART_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
